ha: RTL and testbench

HA -- requirements
Module: ha

---
 rtl/ha_pkg.sv | 8 +
 rtl/ha_sat_counter.sv | 44 ++++
 rtl/ha.sv | 85 ++++++++
 tb/tb_ha.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ha_pkg.sv
// Shared constants for the half-adder block: default lane count and
// activity-counter width.
package ha_pkg;

  localparam int unsigned HA_WIDTH = 1;
  localparam int unsigned HA_CNT_W = 16;

endpackage

// File: rtl/ha_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment
// and the count sticks at all-ones instead of wrapping.
module ha_sat_counter
  import ha_pkg::*;
#(
  parameter int unsigned CNT_W = HA_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next-count selection: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ha.sv
// Registered multi-lane half adder with per-register activity counters
// that count cycles in which the sum or carry register changed.
module ha
  import ha_pkg::*;
#(
  parameter int unsigned WIDTH = HA_WIDTH,
  parameter int unsigned CNT_W = HA_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid,
  output logic [CNT_W-1:0] sum_toggles,
  output logic [CNT_W-1:0] carry_toggles
);

  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] carry_q;
  logic [WIDTH-1:0] carry_d;
  logic             valid_q;
  logic             valid_d;
  logic             sum_chg_s;
  logic             carry_chg_s;

  // lane-wise half add; registers hold when no new operands arrive
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d   = a ^ b;
      carry_d = a & b;
    end else begin
      sum_d   = sum_q;
      carry_d = carry_q;
    end
    // any changed bit counts as a single toggle event
    sum_chg_s   = (sum_d != sum_q);
    carry_chg_s = (carry_d != carry_q);
  end

  // result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  ha_sat_counter #(
    .CNT_W (CNT_W)
  ) u_sum_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_cnt),
    .inc_i (sum_chg_s),
    .cnt_o (sum_toggles)
  );

  ha_sat_counter #(
    .CNT_W (CNT_W)
  ) u_carry_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_cnt),
    .inc_i (carry_chg_s),
    .cnt_o (carry_toggles)
  );

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_ha.sv
// Self-checking bench for ha: a 1-lane default instance and a 4-lane
// instance with 2-bit counters, checked against a result scoreboard.
module tb_ha;

  logic        clk = 1'b0;
  logic        rst;

  logic [0:0]  a1, b1, sum1, carry1;
  logic        iv1, clr1, ov1;
  logic [15:0] st1, ct1;

  logic [3:0]  a4, b4, sum4, carry4;
  logic        iv4, clr4, ov4;
  logic [1:0]  st4, ct4;

  int checks   = 0;
  int failures = 0;

  logic [1:0] sb1[$];
  logic [7:0] sb4[$];

  // truth table indexed by {a,b}
  logic [3:0] sum_tt   = 4'b0110;
  logic [3:0] carry_tt = 4'b1000;

  always #5 clk = ~clk;

  ha u_dut (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(iv1), .clr_cnt(clr1),
    .sum(sum1), .carry(carry1), .out_valid(ov1),
    .sum_toggles(st1), .carry_toggles(ct1)
  );

  ha #(.WIDTH(4), .CNT_W(2)) u_w4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(iv4), .clr_cnt(clr4),
    .sum(sum4), .carry(carry4), .out_valid(ov4),
    .sum_toggles(st4), .carry_toggles(ct4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a1 = 1'b0; b1 = 1'b0; iv1 = 1'b0; clr1 = 1'b0;
    a4 = 4'b0; b4 = 4'b0; iv4 = 1'b0; clr4 = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    sb1.delete();
    sb4.delete();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++; if (sum1 !== 1'b0)   begin failures++; $display("FAIL reset_sum got %0h expected 0", sum1); end
    checks++; if (carry1 !== 1'b0) begin failures++; $display("FAIL reset_carry got %0h expected 0", carry1); end
    checks++; if (ov1 !== 1'b0)    begin failures++; $display("FAIL reset_valid got %0h expected 0", ov1); end
    checks++; if (st1 !== 16'd0)   begin failures++; $display("FAIL reset_sum_toggles got %0d expected 0", st1); end
    checks++; if (ct1 !== 16'd0)   begin failures++; $display("FAIL reset_carry_toggles got %0d expected 0", ct1); end
    checks++; if ({sum4, carry4, ov4, st4, ct4} !== 13'd0) begin
      failures++; $display("FAIL reset_w4 got %0h expected 0", {sum4, carry4, ov4, st4, ct4});
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [1:0] ab;
    logic [1:0] exp;
    for (int i = 0; i < 4; i++) begin
      ab  = 2'(i);
      a1  = ab[1];
      b1  = ab[0];
      iv1 = 1'b1;
      sb1.push_back({sum_tt[ab], carry_tt[ab]});
      step();
      checks++;
      if (ov1 !== 1'b1) begin
        failures++; $display("FAIL tt_valid[%0d] got %0h expected 1", i, ov1);
      end else if (sb1.size() > 0) begin
        exp = sb1.pop_front();
        checks++;
        if ({sum1, carry1} !== exp) begin
          failures++; $display("FAIL tt_result[%0d] got %b expected %b", i, {sum1, carry1}, exp);
        end
      end
    end
    iv1 = 1'b0;
  endtask

  task automatic test_hold();
    logic [1:0] exp;
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
    sb1.push_back(2'b01);
    step();
    checks++;
    if (ov1 !== 1'b1 || sb1.size() == 0) begin
      failures++; $display("FAIL hold_load_valid got %0h expected 1", ov1);
    end else begin
      exp = sb1.pop_front();
      checks++;
      if ({sum1, carry1} !== exp) begin
        failures++; $display("FAIL hold_load got %b expected %b", {sum1, carry1}, exp);
      end
    end
    iv1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a1 = 1'($urandom_range(1, 0));
      b1 = ~a1;
      step();
      checks++;
      if ({sum1, carry1, ov1} !== 3'b010) begin
        failures++; $display("FAIL hold_cycle[%0d] got %b expected 010", k, {sum1, carry1, ov1});
      end
    end
  endtask

  task automatic test_toggle_count();
    logic [1:0] seq [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      a1 = seq[k][1]; b1 = seq[k][0]; iv1 = 1'b1;
      step();
    end
    checks++; if (st1 !== 16'd2) begin failures++; $display("FAIL toggle_sum got %0d expected 2", st1); end
    checks++; if (ct1 !== 16'd2) begin failures++; $display("FAIL toggle_carry got %0d expected 2", ct1); end
    // clear collides with a sum change: clear must win, result still loads
    a1 = 1'b0; b1 = 1'b1; clr1 = 1'b1;
    step();
    checks++; if (st1 !== 16'd0) begin failures++; $display("FAIL clr_sum_toggles got %0d expected 0", st1); end
    checks++; if (ct1 !== 16'd0) begin failures++; $display("FAIL clr_carry_toggles got %0d expected 0", ct1); end
    checks++; if ({sum1, carry1, ov1} !== 3'b101) begin
      failures++; $display("FAIL clr_result got %b expected 101", {sum1, carry1, ov1});
    end
    clr1 = 1'b0; iv1 = 1'b0;
  endtask

  task automatic test_saturate();
    logic [1:0] exp;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      a4 = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      b4 = 4'b0000; iv4 = 1'b1;
      step();
      exp = (k + 1 > 3) ? 2'd3 : 2'(k + 1);
      checks++;
      if (st4 !== exp) begin
        failures++; $display("FAIL sat_sum_toggles[%0d] got %0d expected %0d", k, st4, exp);
      end
    end
    checks++; if (ct4 !== 2'd0) begin failures++; $display("FAIL sat_carry_toggles got %0d expected 0", ct4); end
    iv4 = 1'b0;
  endtask

  task automatic test_wide();
    logic [7:0] exp;
    a4 = 4'b1100; b4 = 4'b1010; iv4 = 1'b1;
    sb4.push_back({4'b0110, 4'b1000});
    step();
    checks++;
    if (ov4 !== 1'b1 || sb4.size() == 0) begin
      failures++; $display("FAIL wide_valid got %0h expected 1", ov4);
    end else begin
      exp = sb4.pop_front();
      checks++;
      if ({sum4, carry4} !== exp) begin
        failures++; $display("FAIL wide_result got %b expected %b", {sum4, carry4}, exp);
      end
    end
    iv4 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] es, ec;
    logic [1:0] idx;
    logic [7:0] exp;
    for (int k = 0; k < 8; k++) begin
      a4 = 4'($urandom_range(15, 0));
      b4 = 4'($urandom_range(15, 0));
      iv4 = 1'b1;
      for (int j = 0; j < 4; j++) begin
        idx   = {a4[j], b4[j]};
        es[j] = sum_tt[idx];
        ec[j] = carry_tt[idx];
      end
      sb4.push_back({es, ec});
      step();
      checks++;
      if (ov4 !== 1'b1 || sb4.size() == 0) begin
        failures++; $display("FAIL b2b_valid[%0d] got %0h expected 1", k, ov4);
      end else begin
        exp = sb4.pop_front();
        checks++;
        if ({sum4, carry4} !== exp) begin
          failures++; $display("FAIL b2b_result[%0d] got %b expected %b", k, {sum4, carry4}, exp);
        end
      end
    end
    iv4 = 1'b0;
    step();
    checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL b2b_idle_valid got %0h expected 0", ov4); end
    checks++; if (sb4.size() != 0) begin failures++; $display("FAIL b2b_drain got %0d pending expected 0", sb4.size()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    a1 = 1'b1; b1 = 1'b0; iv1 = 1'b1;
    step();
    checks++; if (sum1 !== 1'b1) begin failures++; $display("FAIL ar_pre_sum got %0h expected 1", sum1); end
    // in-flight operands when reset hits between edges
    a1 = 1'b1; b1 = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({sum1, carry1, ov1} !== 3'b000) begin
      failures++; $display("FAIL ar_immediate got %b expected 000", {sum1, carry1, ov1});
    end
    checks++; if ({st1, ct1} !== 32'd0) begin
      failures++; $display("FAIL ar_immediate_cnt got %0h expected 0", {st1, ct1});
    end
    step();
    rst = 1'b0;
    iv1 = 1'b0;
    step();
    checks++; if ({sum1, carry1, ov1} !== 3'b000) begin
      failures++; $display("FAIL ar_after_release got %b expected 000", {sum1, carry1, ov1});
    end
    checks++; if ({st1, ct1} !== 32'd0) begin
      failures++; $display("FAIL ar_after_release_cnt got %0h expected 0", {st1, ct1});
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_hold();
    test_toggle_count();
    test_saturate();
    test_wide();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
